// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU encodings, RV32I opcode constants and compare selectors used by
// the ID/EX issue stage and the execute-stage ALU.
package id_ex_alu_issue_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SRL = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_ADD = 4'b0110,
    ALU_SUB = 4'b0111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] CMP_EQ   = 3'b000;
  localparam logic [2:0] CMP_NE   = 3'b001;
  localparam logic [2:0] CMP_SLT  = 3'b010;
  localparam logic [2:0] CMP_SLTU = 3'b011;
  localparam logic [2:0] CMP_LT   = 3'b100;
  localparam logic [2:0] CMP_GE   = 3'b101;
  localparam logic [2:0] CMP_LTU  = 3'b110;
  localparam logic [2:0] CMP_GEU  = 3'b111;

  typedef struct packed {
    logic            illegal;
    alu_op_e         alucntl;
    logic [2:0]      funct;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } alu_issue_t;

endpackage

// File: rtl/id_ex_alu_issue_alu_decode.sv
// Combinational RV32I decode into ALU op, compare selector and operands.
// Every illegal encoding collapses to one canonical ADD-of-zero entry.
module alu_decode
  import id_ex_alu_issue_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output alu_issue_t      dec
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            is_op;
  logic            unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};
  assign is_op  = (opcode == OPC_OP);
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    dec         = '0;
    dec.alucntl = ALU_ADD;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec.op1 = rs1_data;
        dec.op2 = is_op ? rs2_data : imm_i;
        case (funct3)
          3'b000: dec.alucntl = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: begin
            dec.alucntl = ALU_SLL;
            if (!is_op) begin
              dec.op2     = shamt;
              dec.illegal = (funct7 != 7'b0000000);
            end
          end
          3'b010, 3'b011: begin
            dec.alucntl = ALU_SUB;
            dec.funct   = funct3;
          end
          3'b100: dec.alucntl = ALU_XOR;
          3'b101: begin
            dec.alucntl = funct7[5] ? ALU_SRA : ALU_SRL;
            if (!is_op) begin
              dec.op2     = shamt;
              dec.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
          end
          3'b110: dec.alucntl = ALU_OR;
          default: dec.alucntl = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        dec.alucntl = ALU_SUB;
        dec.funct   = funct3;
        dec.op1     = rs1_data;
        dec.op2     = rs2_data;
        dec.illegal = (funct3 == CMP_SLT) || (funct3 == CMP_SLTU);
      end
      OPC_LOAD: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_i;
      end
      OPC_STORE: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_s;
      end
      OPC_LUI: dec.op2 = imm_u;
      OPC_AUIPC: begin
        dec.op1 = pc;
        dec.op2 = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        dec.op1 = pc;
        dec.op2 = 32'd4;
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal entries still flow through the pipe, but carry no operand data.
    if (dec.illegal) begin
      dec.alucntl = ALU_ADD;
      dec.funct   = 3'b000;
      dec.op1     = '0;
      dec.op2     = '0;
    end
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// One-entry registered ID->EX issue stage: decodes an RV32I instruction and
// holds the ALU operation under a valid/ready handshake with flush.
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ALUcntl,
  output logic [2:0]      funct,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic            illegal
);

  alu_issue_t dec;
  alu_issue_t entry_d;
  alu_issue_t entry_q;
  logic       out_valid_d;
  logic       out_valid_q;

  alu_decode u_alu_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    entry_d     = entry_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid_d = 1'b1;
      entry_d     = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      entry_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      entry_q     <= entry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALUcntl   = entry_q.alucntl;
  assign funct     = entry_q.funct;
  assign op1       = entry_q.op1;
  assign op2       = entry_q.op2;
  assign illegal   = entry_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed plus table-driven random bench for id_ex_alu_issue with a
// reference model of the issue register and instruction decode.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] rs1_data = 32'h0;
  logic [31:0] rs2_data = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  ALUcntl;
  logic [2:0]  funct;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        illegal;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  id_ex_alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ALUcntl(ALUcntl), .funct(funct), .op1(op1), .op2(op2), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ill;
    logic [3:0]  c;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  // ALU op selected by funct3 for OP / OP-IMM, indexed by funct3.
  logic [3:0] f3op [8] = '{4'd6, 4'd3, 4'd7, 4'd7, 4'd2, 4'd4, 4'd1, 4'd0};

  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] p,
                                     input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] iimm = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] uimm = {ins[31:12], 12'h000};
    logic [31:0] sh = {27'd0, ins[24:20]};
    r.ill = 1'b0; r.c = 4'd6; r.f = 3'd0; r.a = 32'd0; r.b = 32'd0;
    case (ins[6:0])
      7'h33, 7'h13: begin
        r.a = a;
        r.b = (ins[6:0] == 7'h33) ? b : iimm;
        r.c = f3op[f3];
        if (f3 == 3'd2 || f3 == 3'd3) r.f = f3;
        if (f3 == 3'd0 && ins[6:0] == 7'h33 && f7[5]) r.c = 4'd7;
        if (f3 == 3'd5 && f7[5]) r.c = 4'd5;
        if (ins[6:0] == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          r.b = sh;
          r.ill = (f3 == 3'd1) ? (f7 != 7'h00) : (f7 != 7'h00 && f7 != 7'h20);
        end
      end
      7'h63: begin
        r.c = 4'd7; r.f = f3; r.a = a; r.b = b;
        r.ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h03: begin r.a = a; r.b = iimm; end
      7'h23: begin r.a = a; r.b = simm; end
      7'h37: r.b = uimm;
      7'h17: begin r.a = p; r.b = uimm; end
      7'h6F, 7'h67: begin r.a = p; r.b = 32'd4; end
      default: r.ill = 1'b1;
    endcase
    if (r.ill) begin r.c = 4'd6; r.f = 3'd0; r.a = 32'd0; r.b = 32'd0; end
    return r;
  endfunction

  // Expected register contents, advanced from the handshake rules each edge.
  logic m_valid;
  exp_t m_e;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_e = '{1'b0, 4'd0, 3'd0, 32'd0, 32'd0};
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid = 1'b1;
      m_e = model_dec(instr, pc, rs1_data, rs2_data);
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
      cmp("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      cmp("illegal", {31'd0, illegal}, {31'd0, m_e.ill});
      cmp("ALUcntl", {28'd0, ALUcntl}, {28'd0, m_e.c});
      cmp("funct", {29'd0, funct}, {29'd0, m_e.f});
      cmp("op1", op1, m_e.a);
      cmp("op2", op2, m_e.b);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v; instr = i; pc = p; rs1_data = a; rs2_data = b;
  endtask

  logic [31:0] itab [16] = '{
    32'h002081B3, 32'h402081B3, 32'h40435293, 32'hFFF00093,
    32'h0020C063, 32'h0020B1B3, 32'h123450B7, 32'h12345097,
    32'h008000EF, 32'hFFC12083, 32'h00112423, 32'h40101093,
    32'h0020A063, 32'hFFFFFFFF, 32'h0020D1B3, 32'h000100E7
  };

  initial begin
    logic [31:0] held_c;
    out_ready = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    cmp("rst_out_valid", {31'd0, out_valid}, 32'd0);
    cmp("rst_in_ready", {31'd0, in_ready}, 32'd1);
    cmp("rst_ALUcntl", {28'd0, ALUcntl}, 32'd0);

    drive(1, 32'h002081B3, 32'h0, 32'd10, 32'd20);
    cyc();
    cmp("add_valid", {31'd0, out_valid}, 32'd1);
    cmp("add_cntl", {28'd0, ALUcntl}, 32'd6);
    cmp("add_op1", op1, 32'd10);
    cmp("add_op2", op2, 32'd20);
    cmp("add_funct", {29'd0, funct}, 32'd0);

    drive(1, 32'h402081B3, 32'h0, 32'd10, 32'd20);
    cyc();
    cmp("sub_cntl", {28'd0, ALUcntl}, 32'd7);
    cmp("sub_funct", {29'd0, funct}, 32'd0);

    drive(1, 32'h40435293, 32'h0, 32'h80000000, 32'd0);
    cyc();
    cmp("srai_cntl", {28'd0, ALUcntl}, 32'd5);
    cmp("srai_op2", op2, 32'd4);

    drive(1, 32'hFFF00093, 32'h0, 32'd0, 32'd7);
    cyc();
    cmp("addi_cntl", {28'd0, ALUcntl}, 32'd6);
    cmp("addi_op2", op2, 32'hFFFFFFFF);

    drive(1, 32'h0020C063, 32'h0, 32'd3, 32'd4);
    cyc();
    cmp("blt_cntl", {28'd0, ALUcntl}, 32'd7);
    cmp("blt_funct", {29'd0, funct}, 32'd4);

    // Stall three cycles with a new XOR waiting, then release.
    out_ready = 1'b0;
    drive(1, 32'h0020C1B3, 32'h0, 32'd5, 32'd6);
    held_c = {28'd0, ALUcntl};
    for (int k = 0; k < 3; k++) begin
      cyc();
      cmp("stall_in_ready", {31'd0, in_ready}, 32'd0);
      cmp("stall_cntl", {28'd0, ALUcntl}, held_c);
      cmp("stall_op1", op1, 32'd3);
    end
    out_ready = 1'b1;
    cyc();
    cmp("release_valid", {31'd0, out_valid}, 32'd1);
    cmp("release_cntl", {28'd0, ALUcntl}, 32'd2);

    drive(1, 32'h002081B3, 32'h0, 32'd1, 32'd2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cmp("flush_valid", {31'd0, out_valid}, 32'd0);

    drive(1, 32'hFFFFFFFF, 32'h100, 32'd5, 32'd9);
    cyc();
    cmp("illegal_flag", {31'd0, illegal}, 32'd1);
    cmp("illegal_op1", op1, 32'd0);
    cmp("illegal_op2", op2, 32'd0);

    drive(1, 32'h12345097, 32'h400, 32'd0, 32'd0);
    cyc();
    cmp("auipc_op1", op1, 32'h400);
    cmp("auipc_op2", op2, 32'h12345000);

    drive(1, 32'h00112423, 32'h0, 32'h100, 32'd0);
    cyc();
    cmp("sw_op2", op2, 32'd8);

    drive(1, 32'h40101093, 32'h0, 32'd1, 32'd0);
    cyc();
    cmp("slli_bad", {31'd0, illegal}, 32'd1);

    drive(0, 32'h0, 32'h0, 32'd0, 32'd0);
    cyc();
    cmp("drain_valid", {31'd0, out_valid}, 32'd0);

    // Reset while stalled drops the held entry.
    out_ready = 1'b0;
    drive(1, 32'h002081B3, 32'h0, 32'd11, 32'd22);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cmp("rststall_valid", {31'd0, out_valid}, 32'd0);
    cmp("rststall_op1", op1, 32'd0);
    cmp("rststall_in_ready", {31'd0, in_ready}, 32'd1);

    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, itab[$urandom_range(0, 15)],
            $urandom, $urandom, $urandom);
      if ($urandom_range(0, 7) == 0) instr = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      cyc();
    end
    flush = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
ID_EX_ALU_ISSUE -- requirements
Module: id_ex_alu_issue

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 in_valid  input  1  decode stage presents an instruction.
REQ-004 in_ready  output  1  block accepts the instruction this cycle.
REQ-005 instr  input  32  raw RV32I instruction word.
REQ-006 pc  input  32  address of instr.
REQ-007 rs1_data, rs2_data  input  32 each  register-file read values.
REQ-008 flush  input  1  discard held and incoming instruction (branch redirect).
REQ-009 out_valid  output  1  registered ALU operation is valid.
REQ-010 out_ready  input  1  execute stage consumes the operation.
REQ-011 ALUcntl  output  4  ALU op: 0000 AND, 0001 OR, 0010 XOR, 0011 SLL, 0100 SRL, 0101 SRA, 0110 ADD, 0111 SUB/compare.
REQ-012 funct  output  3  compare selector, meaningful only when ALUcntl=0111.
REQ-013 op1, op2  output  32 each  ALU operands.
REQ-014 illegal  output  1  held instruction has an unsupported opcode or encoding.

Function
REQ-015 The block SHALL be a one-entry registered issue stage; in_ready = !out_valid || out_ready (combinational).
REQ-016 A transfer SHALL occur when in_valid && in_ready; decoded fields are registered on that edge and out_valid is 1 the following cycle (latency 1).
REQ-017 When out_valid && !out_ready, all outputs SHALL hold stable; when out_ready && !in_valid, out_valid SHALL clear next cycle.
REQ-018 Simultaneous accept and consume SHALL replace the entry with no bubble.
REQ-019 flush SHALL clear out_valid next cycle and block capture that cycle, overriding in_valid and out_ready.
REQ-020 OP (0110011): op1=rs1_data, op2=rs2_data; funct3 000 -> ADD (funct7[5]=0) or SUB (funct7[5]=1); 001 SLL; 010 -> 0111/funct 010; 011 -> 0111/funct 011; 100 XOR; 101 SRL or SRA by funct7[5]; 110 OR; 111 AND.
REQ-021 OP-IMM (0010011): as REQ-020 with op2=sign-extended I-imm, no SUB; shifts use op2={27'b0,shamt}, SRAI by funct7[5]; slli/srli/srai with other funct7 bits set -> illegal.
REQ-022 BRANCH (1100011): ALUcntl=0111, funct=funct3, op1=rs1_data, op2=rs2_data; funct3 010/011 -> illegal.
REQ-023 LOAD (0000011) and STORE (0100011): ADD, op1=rs1_data, op2=sign-extended I-imm or S-imm.
REQ-024 LUI: ADD, op1=0, op2={imm[31:12],12'b0}; AUIPC: same op2, op1=pc.
REQ-025 JAL, JALR: ADD, op1=pc, op2=32'd4 (link value).
REQ-026 funct SHALL be 000 for every op other than compare/branch, including SUB.
REQ-027 Any other opcode SHALL register illegal=1, ALUcntl=0110, op1=op2=0, funct=000, and still handshake normally.
REQ-028 All arithmetic is 32-bit; immediates sign-extend from bit 31 of instr.

Reset
REQ-029 On rst, out_valid=0, illegal=0, ALUcntl=0000, funct=000, op1=op2=0 next edge; rst overrides flush and in_valid.
REQ-030 Reset mid-stall SHALL drop the held entry; in_ready=1 the cycle after reset.

Structure
REQ-031 ALU op encodings (4-bit), opcode constants and compare funct codes SHALL live in a shared package used by the ALU and this block.
REQ-032 Combinational decode SHALL be one sub-module, alu_decode; the top holds only the pipeline register and handshake.

Verification
REQ-033 0x002081B3 (ADD x3,x1,x2), rs1=10, rs2=20 -> next cycle out_valid=1, ALUcntl=0110, op1=10, op2=20, funct=000.
REQ-034 0x402081B3 (SUB) -> ALUcntl=0111, funct=000; 0x40435293 (SRAI x5,x6,4) -> ALUcntl=0101, op2=4.
REQ-035 0xFFF00093 (ADDI x1,x0,-1), rs1=0 -> ALUcntl=0110, op2=0xFFFFFFFF; 0x0020C063 (BLT) -> ALUcntl=0111, funct=100.
REQ-036 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> new instruction captured same edge, no bubble.
REQ-037 flush with in_valid=1 and held entry -> out_valid=0 next cycle; instr 0xFFFFFFFF -> illegal=1, op1=op2=0; rst during stall -> all outputs zero.
